// File: rtl/uart_frame_tx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : uart_frame_tx
// Purpose  : Serialises a 40-byte frame over an 8N1 UART line. The payload is
//            latched on acceptance and sent most-significant byte first, with
//            each byte sent LSB first. Completion is signalled with a 4-phase
//            send/send_done handshake.
// Ports    : clk        - system clock, rising edge
//            rst        - asynchronous reset, active low
//            send       - frame request from the upstream frame generator
//            data       - 320-bit payload, byte 0 = data[319:312]
//            send_done  - frame complete, held until send is seen low
//            tx         - UART serial line, idles high
//            busy       - high whenever the block is not idle
// Revision : 1.0 - initial release
// ============================================================================
module uart_frame_tx #(
  parameter int CLK_FREQ = 50000000,
  parameter int BAUD     = 115200
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         send,
  input  logic [319:0] data,
  output logic         send_done,
  output logic         tx,
  output logic         busy
);

  // Clock cycles per serial bit. Integer truncation is intended.
  localparam int c_DIV = CLK_FREQ / BAUD;

  // The baud counter needs to reach c_DIV-1. A single bit is still kept when
  // c_DIV is 1, so the counter never collapses to zero width.
  localparam int c_BAUD_W = (c_DIV > 1) ? $clog2(c_DIV) : 1;

  localparam logic [c_BAUD_W-1:0] c_BAUD_LAST = c_BAUD_W'(c_DIV - 1);
  localparam logic [c_BAUD_W-1:0] c_BAUD_ONE  = c_BAUD_W'(1);
  localparam logic [5:0]          c_LAST_BYTE = 6'd39;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t                r_state;
  state_t                w_state_next;

  logic [c_BAUD_W-1:0]   r_baud;
  logic [2:0]            r_bit;
  logic [5:0]            r_byte;
  logic [319:0]          r_shift;

  logic                  w_baud_end;
  logic                  w_bit_last;
  logic                  w_byte_last;
  logic                  w_accept;
  logic                  w_next_byte;
  logic [7:0]            w_cur_byte;

  assign w_baud_end  = (r_baud == c_BAUD_LAST);
  assign w_bit_last  = (r_bit == 3'd7);
  assign w_byte_last = (r_byte == c_LAST_BYTE);
  assign w_accept    = (r_state == S_IDLE) && send;

  // End of a stop bit that is not the last one of the frame: advance to the
  // next byte of the payload.
  assign w_next_byte = (r_state == S_STOP) && w_baud_end && !w_byte_last;

  // The byte on the wire always sits in the top eight bits of the shift
  // register; lower bytes move up one slot after each stop bit.
  assign w_cur_byte  = r_shift[319:312];

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and output decode
  // tx is decoded from registered state, so it falls on the very edge that
  // accepts the frame (the state turns to START on that edge). Any reset
  // returns the state to IDLE, which drives tx high at once.
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    tx           = 1'b1;
    send_done    = 1'b0;
    busy         = 1'b1;

    case (r_state)
      S_IDLE: begin
        busy = 1'b0;
        if (send) begin
          w_state_next = S_START;
        end
      end

      S_START: begin
        tx = 1'b0;
        if (w_baud_end) begin
          w_state_next = S_DATA;
        end
      end

      S_DATA: begin
        tx = w_cur_byte[r_bit];
        if (w_baud_end && w_bit_last) begin
          w_state_next = S_STOP;
        end
      end

      S_STOP: begin
        tx = 1'b1;
        if (w_baud_end) begin
          w_state_next = w_byte_last ? S_DONE : S_START;
        end
      end

      S_DONE: begin
        // send_done is high from the first DONE cycle. A send still held
        // high keeps the block here, so a new frame cannot start until
        // send has been seen low.
        send_done = 1'b1;
        if (!send) begin
          w_state_next = S_IDLE;
        end
      end

      default: begin
        w_state_next = S_IDLE;
        busy         = 1'b0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Baud, bit and byte counters
  // The baud counter only runs while a bit is on the wire, and wraps on every
  // bit boundary. The bit counter wraps from 7 back to 0 as it leaves DATA,
  // so it is already cleared for the next byte.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_baud <= '0;
      r_bit  <= '0;
      r_byte <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_baud <= '0;
          r_bit  <= '0;
          r_byte <= '0;
        end

        S_START, S_DATA, S_STOP: begin
          r_baud <= w_baud_end ? '0 : (r_baud + c_BAUD_ONE);
          if ((r_state == S_DATA) && w_baud_end) begin
            r_bit <= r_bit + 3'd1;
          end
          if (w_next_byte) begin
            r_byte <= r_byte + 6'd1;
          end
        end

        default: begin
          r_baud <= '0;
          r_bit  <= '0;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Payload shift register
  // Loaded only on acceptance, so later changes on data cannot reach a frame
  // in progress. Its contents carry no meaning outside a frame, so it has no
  // reset.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_shift <= data;
    end else if (w_next_byte) begin
      r_shift <= {r_shift[311:0], 8'h00};
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_frame_tx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_uart_frame_tx
// Purpose  : Self-checking bench for uart_frame_tx with DIV = 4. A table of
//            frames is sent and each tx trace is decoded into bytes. Hand
//            sequences cover the DONE hold, re-arming and a mid-frame reset.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_frame_tx;

  localparam logic [319:0] c_ONES  = {320{1'b1}};
  localparam logic [319:0] c_ORDER = {8'hA5, 304'h0, 8'h01};
  localparam logic [319:0] c_RAMP  =
    320'h0102030405060708090A0B0C0D0E0F101112131415161718191A1B1C1D1E1F202122232425262728;

  logic         clk = 1'b0;
  logic         rst;
  logic         send;
  logic [319:0] data;
  logic         send_done;
  logic         tx;
  logic         busy;

  uart_frame_tx #(
    .CLK_FREQ (4),
    .BAUD     (1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .send      (send),
    .data      (data),
    .send_done (send_done),
    .tx        (tx),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // mode 0: send held high; 1: data changed and send toggled during byte 5;
  // 2: send dropped early, so it is already low when DONE is entered.
  typedef struct {
    string        name;
    logic [319:0] d;
    int           mode;
    int           ia;
    logic [7:0]   ea;
    int           ib;
    logic [7:0]   eb;
    int           ic;
    logic [7:0]   ec;
  } vec_t;

  vec_t       vecs [5];
  int         checks = 0;
  int         errors = 0;
  logic       trace [0:1999];
  logic [7:0] rx_bytes [0:39];
  logic       frame_ok;
  int         done_at;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Starts a frame and records tx for each cycle until send_done rises.
  // Cycle 0 is the acceptance edge. It returns one step after the edge on
  // which send_done was first seen.
  task automatic run_frame(input logic [319:0] d, input int mode);
    @(negedge clk);
    data = d;
    send = 1'b1;
    @(posedge clk);
    #1;
    check("accept_tx", 64'(tx), 64'(1'b0));
    check("accept_busy", 64'(busy), 64'(1'b1));
    trace[0] = tx;
    done_at  = 2000;
    for (int n = 1; n < 2000; n++) begin
      @(posedge clk);
      #1;
      if (send_done) begin
        done_at = n;
        break;
      end
      trace[n] = tx;
      if (mode == 1 && n == 210) begin
        data = ~d;
        send = 1'b0;
      end
      if (mode == 1 && n == 225) begin
        send = 1'b1;
      end
      if (mode == 2 && n == 100) begin
        send = 1'b0;
      end
    end
    check("frame_len", 64'(done_at), 64'(1600));

    // 40 bytes of 10 bits, 4 cycles each: start 0, 8 data bits LSB first,
    // stop 1. Every bit must keep its value for all four cycles.
    frame_ok = 1'b1;
    for (int b = 0; b < 40; b++) begin
      for (int j = 0; j < 10; j++) begin
        int base;
        base = b * 40 + j * 4;
        for (int k = 1; k < 4; k++) begin
          if (trace[base + k] !== trace[base]) frame_ok = 1'b0;
        end
        if (j == 0 && trace[base] !== 1'b0) frame_ok = 1'b0;
        if (j == 9 && trace[base] !== 1'b1) frame_ok = 1'b0;
        if (j >= 1 && j <= 8) rx_bytes[b][j - 1] = trace[base];
      end
    end
    check("framing", 64'(frame_ok), 64'(1'b1));
  endtask

  // Holds send high for a number of DONE cycles, then drops it. The block
  // must be idle after the next edge.
  task automatic finish_frame(input int hold);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      check("hold_send_done", 64'(send_done), 64'(1'b1));
      check("hold_tx", 64'(tx), 64'(1'b1));
    end
    send = 1'b0;
    @(posedge clk);
    #1;
    check("idle_send_done", 64'(send_done), 64'(1'b0));
    check("idle_busy", 64'(busy), 64'(1'b0));
    check("idle_tx", 64'(tx), 64'(1'b1));
  endtask

  initial begin
    vecs[0] = '{"ones",   c_ONES,  0, 0, 8'hFF, 20, 8'hFF, 39, 8'hFF};
    vecs[1] = '{"order",  c_ORDER, 0, 0, 8'hA5,  1, 8'h00, 39, 8'h01};
    vecs[2] = '{"ramp",   c_RAMP,  0, 0, 8'h01, 20, 8'h15, 39, 8'h28};
    vecs[3] = '{"stable", c_RAMP,  1, 5, 8'h06,  6, 8'h07, 39, 8'h28};
    vecs[4] = '{"early",  c_ORDER, 2, 0, 8'hA5, 38, 8'h00, 39, 8'h01};

    rst  = 1'b0;
    send = 1'b0;
    data = '0;

    // Reset state while rst is held low.
    #23;
    check("rst_tx", 64'(tx), 64'(1'b1));
    check("rst_send_done", 64'(send_done), 64'(1'b0));
    check("rst_busy", 64'(busy), 64'(1'b0));
    #4;
    rst = 1'b1;

    for (int i = 0; i < 5; i++) begin
      run_frame(vecs[i].d, vecs[i].mode);
      check($sformatf("%s_byte%0d", vecs[i].name, vecs[i].ia), 64'(rx_bytes[vecs[i].ia]), 64'(vecs[i].ea));
      check($sformatf("%s_byte%0d", vecs[i].name, vecs[i].ib), 64'(rx_bytes[vecs[i].ib]), 64'(vecs[i].eb));
      check($sformatf("%s_byte%0d", vecs[i].name, vecs[i].ic), 64'(rx_bytes[vecs[i].ic]), 64'(vecs[i].ec));
      finish_frame(0);
    end

    // send held high across DONE: the block stays in DONE with no new start.
    run_frame(c_ONES, 0);
    finish_frame(10);

    // Reassert send from idle: a new frame starts on the next edge.
    data = c_RAMP;
    send = 1'b1;
    @(posedge clk);
    #1;
    check("rearm_tx", 64'(tx), 64'(1'b0));
    check("rearm_busy", 64'(busy), 64'(1'b1));

    // Pulse reset during byte 20, away from any clock edge.
    repeat (805) @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    check("midrst_tx", 64'(tx), 64'(1'b1));
    check("midrst_send_done", 64'(send_done), 64'(1'b0));
    check("midrst_busy", 64'(busy), 64'(1'b0));
    repeat (2) @(posedge clk);
    #3;
    rst = 1'b1;

    // The frame after reset must start again from byte 0.
    run_frame(c_RAMP, 0);
    check("restart_byte0", 64'(rx_bytes[0]), 64'(8'h01));
    check("restart_byte20", 64'(rx_bytes[20]), 64'(8'h15));
    check("restart_byte39", 64'(rx_bytes[39]), 64'(8'h28));
    finish_frame(0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
